pipeline_latealu_ctrl: RTL and testbench



---
 rtl/pipeline_latealu_ctrl.sv | 117 +++++++++++
 tb/tb_pipeline_latealu_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pipeline_latealu_ctrl.sv
// pipeline_latealu_ctrl: LateALU sequencer with inline shifts/HI-LO moves and an iterative mult/div engine.
module pipeline_latealu_ctrl #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_a1,
  input  logic [4:0]  req_rd_index,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [4:0]  resp_rd_index,
  output logic [31:0] resp_value,
  output logic        bad_op,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t st, nxt;
  logic [5:0] cnt;
  logic [31:0] a, b, r, sh_res;
  logic sgn, nq, nr, dz, acc, is_sh, is_mul, is_div, is_mf, is_mt, is_bad, sdiv, ok;
  logic signed [65:0] prod;
  logic [32:0] tr;
  assign busy      = st != IDLE;
  assign req_ready = !busy;
  assign acc       = req_valid && req_ready && !flush;
  assign is_sh     = req_op inside {6'd1, 6'd2, 6'd3};
  assign is_mul    = req_op inside {6'd4, 6'd5};
  assign is_div    = req_op inside {6'd6, 6'd7};
  assign is_mf     = req_op inside {6'd8, 6'd9};
  assign is_mt     = req_op inside {6'd10, 6'd11};
  assign is_bad    = !(is_sh || is_mul || is_div || is_mf || is_mt);
  assign sdiv      = req_op == 6'd6;
  assign sh_res    = req_op == 6'd1 ? req_a0 << req_a1[4:0] :
                     req_op == 6'd2 ? req_a0 >> req_a1[4:0] :
                     32'($signed(req_a0) >>> req_a1[4:0]);
  assign prod      = $signed({sgn & a[31], a}) * $signed({sgn & b[31], b});
  // {r, a} is the partial remainder/quotient pair; one restoring step per cycle
  assign tr        = {r, a[31]} - {1'b0, b};
  assign ok        = !tr[32];
  always_comb begin
    nxt = st;
    if (flush) nxt = IDLE;
    else if (st == IDLE) nxt = acc && is_mul ? MUL : acc && is_div ? DIV : IDLE;
    else if (st == MUL) nxt = cnt[0] ? IDLE : MUL;
    else if (st == DIV) nxt = cnt == 6'(DIV_ITERS - 1) ? FIX : DIV;
    else nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      st <= IDLE;
      hi <= '0;
      lo <= '0;
      resp_valid <= 1'b0;
      resp_rd_index <= '0;
      resp_value <= '0;
      bad_op <= 1'b0;
      cnt <= '0;
      a <= '0;
      b <= '0;
      r <= '0;
      sgn <= 1'b0;
      nq <= 1'b0;
      nr <= 1'b0;
      dz <= 1'b0;
    end else begin
      st <= nxt;
      resp_valid <= 1'b0;
      bad_op <= 1'b0;
      if (acc) begin
        if (is_sh || is_mf) begin
          resp_valid <= 1'b1;
          resp_rd_index <= req_rd_index;
          resp_value <= is_sh ? sh_res : req_op == 6'd8 ? hi : lo;
        end
        if (req_op == 6'd10) hi <= req_a0;
        if (req_op == 6'd11) lo <= req_a0;
        bad_op <= is_bad;
        cnt <= '0;
        r <= '0;
        if (is_mul) begin
          a <= req_a0;
          b <= req_a1;
          sgn <= req_op == 6'd4;
        end
        // divide-by-zero keeps the raw dividend in b so FIX can return it as hi
        if (is_div) begin
          a <= sdiv && req_a0[31] ? -req_a0 : req_a0;
          b <= req_a1 == '0 ? req_a0 : sdiv && req_a1[31] ? -req_a1 : req_a1;
          nq <= sdiv && (req_a0[31] ^ req_a1[31]);
          nr <= sdiv && req_a0[31];
          dz <= req_a1 == '0;
        end
      end else if (!flush) begin
        if (st == MUL) begin
          cnt <= cnt + 6'd1;
          if (cnt[0]) {hi, lo} <= {r, a};
          else {r, a} <= prod[63:0];
        end
        if (st == DIV) begin
          cnt <= cnt + 6'd1;
          r <= ok ? tr[31:0] : {r[30:0], a[31]};
          a <= {a[30:0], ok};
        end
        if (st == FIX) begin
          hi <= dz ? b : nr ? -r : r;
          lo <= dz ? '1 : nq ? -a : a;
        end
      end
    end
  end
endmodule

// File: tb/tb_pipeline_latealu_ctrl.sv
// tb_pipeline_latealu_ctrl: directed vectors with hand-computed results for the LateALU sequencer.
module tb_pipeline_latealu_ctrl;
  logic clk = 0, rst = 0, flush = 0, req_valid = 0;
  logic [5:0] req_op = '0;
  logic [31:0] req_a0 = '0, req_a1 = '0;
  logic [4:0] req_rd_index = '0;
  logic req_ready, resp_valid, bad_op, busy;
  logic [4:0] resp_rd_index;
  logic [31:0] resp_value, hi, lo;
  int tests = 0, fails = 0, n;

  pipeline_latealu_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_op(req_op),
    .req_a0(req_a0), .req_a1(req_a1), .req_rd_index(req_rd_index), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rd_index(resp_rd_index), .resp_value(resp_value),
    .bad_op(bad_op), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [5:0] op, input logic [31:0] a0, input logic [31:0] a1, input logic [4:0] rd);
    req_valid = 1; req_op = op; req_a0 = a0; req_a1 = a1; req_rd_index = rd;
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 1);
    check("rst_resp", {resp_valid, bad_op}, 0);
    check("rst_resp_data", {resp_rd_index, resp_value}, 0);
    rst = 1;
    @(negedge clk);

    send(6'd3, 32'h80000010, 32'd4, 5'd5);
    check("sra_valid", resp_valid, 1);
    check("sra_rd", resp_rd_index, 5);
    check("sra_val", resp_value, 32'hF8000001);
    @(negedge clk);
    check("sra_pulse", resp_valid, 0);
    send(6'd2, 32'h80000010, 32'd4, 5'd6);
    check("srl_val", {resp_valid, resp_rd_index, resp_value}, {1'b1, 5'd6, 32'h08000001});
    send(6'd1, 32'h80000010, 32'd36, 5'd7);
    check("sll_val", {resp_valid, resp_rd_index, resp_value}, {1'b1, 5'd7, 32'h00000100});

    send(6'd4, 32'hFFFFFFFE, 32'd3, 5'd1);
    check("mult_noresp", resp_valid, 0);
    wait_idle(n);
    check("mult_busy", n, 2);
    check("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
    send(6'd5, 32'hFFFFFFFE, 32'd3, 5'd1);
    wait_idle(n);
    check("multu_busy", n, 2);
    check("multu_hilo", {hi, lo}, 64'h00000002_FFFFFFFA);

    send(6'd6, 32'hFFFFFFF9, 32'd2, 5'd0);
    req_valid = 1; req_op = 6'd9; req_rd_index = 5'd9;
    check("div_ready0", req_ready, 0);
    n = 0;
    while (!req_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("div_busy", n, 33);
    @(negedge clk);
    req_valid = 0;
    check("mflo_resp", {resp_valid, resp_rd_index, resp_value}, {1'b1, 5'd9, 32'hFFFFFFFD});
    check("div_hi", hi, 32'hFFFFFFFF);

    send(6'd6, 32'd7, 32'hFFFFFFFE, 5'd0);
    wait_idle(n);
    check("div_neg_divisor", {hi, lo}, 64'h00000001_FFFFFFFD);
    send(6'd7, 32'h1234, 32'd0, 5'd0);
    wait_idle(n);
    check("divu_zero_busy", n, 33);
    check("divu_zero", {hi, lo}, 64'h00001234_FFFFFFFF);
    send(6'd6, 32'hFFFFFFF9, 32'd0, 5'd0);
    wait_idle(n);
    check("div_zero_neg", {hi, lo}, 64'hFFFFFFF9_FFFFFFFF);
    send(6'd6, 32'h80000000, 32'hFFFFFFFF, 5'd0);
    wait_idle(n);
    check("div_ovf", {hi, lo}, 64'h00000000_80000000);
    send(6'd7, 32'd100, 32'd7, 5'd0);
    wait_idle(n);
    check("divu_100_7", {hi, lo}, 64'h00000002_0000000E);

    send(6'd10, 32'hA5A5A5A5, 32'd0, 5'd0);
    check("mthi_noresp", resp_valid, 0);
    check("mthi_hi", hi, 32'hA5A5A5A5);
    send(6'd7, 32'd100, 32'd7, 5'd0);
    repeat (9) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    check("flush_busy", {busy, req_ready}, 2'b01);
    check("flush_hilo", {hi, lo}, 64'hA5A5A5A5_0000000E);
    repeat (40) @(negedge clk);
    check("flush_stays", {hi, lo}, 64'hA5A5A5A5_0000000E);
    flush = 1;
    send(6'd8, 32'd0, 32'd0, 5'd3);
    flush = 0;
    check("flush_drop_mf", resp_valid, 0);
    flush = 1;
    send(6'd10, 32'h1, 32'd0, 5'd0);
    flush = 0;
    check("flush_drop_mt", hi, 32'hA5A5A5A5);

    send(6'h3F, 32'd1, 32'd1, 5'd4);
    check("bad_pulse", {bad_op, resp_valid}, 2'b10);
    @(negedge clk);
    check("bad_clear", bad_op, 0);
    check("bad_nochange", {hi, lo, 31'd0, busy}, {64'hA5A5A5A5_0000000E, 32'd0});

    send(6'd6, 32'd100, 32'd7, 5'd0);
    repeat (5) @(negedge clk);
    rst = 0;
    @(negedge clk);
    rst = 1;
    check("rst_mid_hilo", {hi, lo}, 0);
    check("rst_mid_state", {busy, req_ready}, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
